// File: rtl/skew_feeder.sv
// Double-buffered skew injector for one systolic-array edge: loads a tile of
// VEC_LEN beats into one bank while the other bank replays it lane-skewed.
module skew_feeder #(
  parameter int DATA_W       = 16,
  parameter int LANES        = 32,
  parameter int VEC_LEN      = 32,
  parameter bit SKEW_REVERSE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data [0:LANES-1],
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data [0:LANES-1],
  output logic              tile_last,
  output logic              busy
);

  localparam int S     = VEC_LEN + LANES - 1;
  localparam int IDX_W = $clog2(VEC_LEN);
  localparam int CNT_W = $clog2(S);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(S - 1);
  localparam logic [CNT_W-1:0] CNT_VEC  = CNT_W'(VEC_LEN);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    STREAMING
  } bank_state_t;

  bank_state_t      bank_state     [2];
  bank_state_t      bank_state_nxt [2];
  logic             wr_bank, wr_bank_nxt;
  logic [IDX_W-1:0] wr_idx,  wr_idx_nxt;
  logic             rd_bank, rd_bank_nxt;
  logic [CNT_W-1:0] rd_cnt,  rd_cnt_nxt;
  logic             wr_fire;
  logic             rd_fire;

  logic [DATA_W-1:0] mem [2][VEC_LEN][LANES];

  function automatic logic [CNT_W-1:0] lane_delay(int lane);
    return SKEW_REVERSE ? CNT_W'(LANES - 1 - lane) : CNT_W'(lane);
  endfunction

  // Every output is decoded from registered bank state, so in_ready never sees out_ready.
  assign in_ready  = (bank_state[wr_bank] == EMPTY) || (bank_state[wr_bank] == FILLING);
  assign out_valid = (bank_state[rd_bank] == FULL) || (bank_state[rd_bank] == STREAMING);
  assign tile_last = out_valid && (rd_cnt == CNT_LAST);
  assign busy      = (bank_state[0] != EMPTY) || (bank_state[1] != EMPTY);
  assign wr_fire   = in_valid && in_ready && !flush;
  assign rd_fire   = out_valid && out_ready;

  // NOTE: every always_comb output is assigned a default first so no latch is inferred.
  always_comb begin
    bank_state_nxt = bank_state;
    wr_bank_nxt    = wr_bank;
    wr_idx_nxt     = wr_idx;
    rd_bank_nxt    = rd_bank;
    rd_cnt_nxt     = rd_cnt;
    if (flush) begin
      bank_state_nxt[0] = EMPTY;
      bank_state_nxt[1] = EMPTY;
      wr_bank_nxt       = 1'b0;
      wr_idx_nxt        = '0;
      rd_bank_nxt       = 1'b0;
      rd_cnt_nxt        = '0;
    end else begin
      // The write bank is EMPTY/FILLING and the read bank FULL/STREAMING, so they never collide.
      if (wr_fire) begin
        if (wr_idx == IDX_LAST) begin
          bank_state_nxt[wr_bank] = FULL;
          wr_idx_nxt              = '0;
          wr_bank_nxt             = ~wr_bank;
        end else begin
          bank_state_nxt[wr_bank] = FILLING;
          wr_idx_nxt              = wr_idx + 1'b1;
        end
      end
      if (out_valid) begin
        if (rd_fire && tile_last) begin
          bank_state_nxt[rd_bank] = EMPTY;
          rd_cnt_nxt              = '0;
          rd_bank_nxt             = ~rd_bank;
        end else begin
          bank_state_nxt[rd_bank] = STREAMING;
          if (rd_fire) rd_cnt_nxt = rd_cnt + 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_state[0] <= EMPTY;
      bank_state[1] <= EMPTY;
      wr_bank       <= 1'b0;
      wr_idx        <= '0;
      rd_bank       <= 1'b0;
      rd_cnt        <= '0;
    end else begin
      bank_state <= bank_state_nxt;
      wr_bank    <= wr_bank_nxt;
      wr_idx     <= wr_idx_nxt;
      rd_bank    <= rd_bank_nxt;
      rd_cnt     <= rd_cnt_nxt;
    end
  end

  // NOTE: tile storage is not reset; bank state gates every read, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < LANES; i++) mem[wr_bank][wr_idx][i] <= in_data[i];
    end
  end

  // Lane i shows beat rd_cnt-d_i of the streaming bank, zero outside the tile window.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      out_data[i] = '0;
      if (out_valid && (rd_cnt >= lane_delay(i)) && ((rd_cnt - lane_delay(i)) < CNT_VEC)) begin
        out_data[i] = mem[rd_bank][IDX_W'(rd_cnt - lane_delay(i))][i];
      end
    end
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Directed bench for skew_feeder (LANES=4, VEC_LEN=4): forward and reversed
// instances share stimulus; every wavefront element is checked against a model.
module tb_skew_feeder;

  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int VLEN   = 4;
  localparam int S      = VLEN + LANES - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data [0:LANES-1];
  logic              out_ready = 1'b1;

  logic              in_ready, out_valid, tile_last, busy;
  logic [DATA_W-1:0] out_data [0:LANES-1];
  logic              r_in_ready, r_out_valid, r_tile_last, r_busy;
  logic [DATA_W-1:0] r_out_data [0:LANES-1];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int bubbles, n_valid;
  int first_acc [16];
  int last_acc [16];
  int last_hs [16];
  int first_valid [16];

  skew_feeder #(.DATA_W(DATA_W), .LANES(LANES), .VEC_LEN(VLEN), .SKEW_REVERSE(1'b0)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .tile_last(tile_last), .busy(busy)
  );

  skew_feeder #(.DATA_W(DATA_W), .LANES(LANES), .VEC_LEN(VLEN), .SKEW_REVERSE(1'b1)) dut_rev (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r_in_ready),
    .in_data(in_data), .out_ready(out_ready), .out_valid(r_out_valid), .out_data(r_out_data),
    .tile_last(r_tile_last), .busy(r_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Element k of lane i in tile n is n*0x100 + 16*i + k.
  function automatic logic [31:0] exp_val(int tile, int t, int lane, bit rev);
    int d;
    int k;
    d = rev ? (LANES - 1 - lane) : lane;
    k = t - d;
    if (k >= 0 && k < VLEN) return 32'(tile * 256 + 16 * lane + k);
    return 32'd0;
  endfunction

  task automatic drive_beat(input int tile, input int k, output int acc_cyc);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    for (int i = 0; i < LANES; i++) in_data[i] = 16'(tile * 256 + 16 * i + k);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 200) begin
        check("in_ready_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_tile(input int tile);
    int acc;
    for (int k = 0; k < VLEN; k++) begin
      drive_beat(tile, k, acc);
      if (k == 0) first_acc[tile] = acc;
    end
    last_acc[tile] = acc;
  endtask

  task automatic collect(input int first_tile, input int n_tiles, input bit stall);
    int t, tile, hs, guard;
    bit started;
    t = 0; tile = first_tile; hs = 0; guard = 0; started = 1'b0;
    bubbles = 0; n_valid = 0;
    while (hs < n_tiles * S && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (out_valid) begin
        started = 1'b1;
        n_valid++;
        if (t == 0 && first_valid[tile] < 0) first_valid[tile] = cyc;
        for (int i = 0; i < LANES; i++) begin
          check($sformatf("fwd tile%0d t%0d lane%0d", tile, t, i), 32'(out_data[i]), exp_val(tile, t, i, 1'b0));
          check($sformatf("rev tile%0d t%0d lane%0d", tile, t, i), 32'(r_out_data[i]), exp_val(tile, t, i, 1'b1));
        end
        check($sformatf("tile_last t%0d", t), 32'(tile_last), 32'(t == S - 1));
        check($sformatf("rev tile_last t%0d", t), 32'(r_tile_last), 32'(t == S - 1));
        if (out_ready) begin
          if (t == S - 1) last_hs[tile] = cyc;
          hs++;
          t++;
          if (t == S) begin
            t = 0;
            tile++;
          end
        end
      end else if (started) begin
        bubbles++;
      end
      @(posedge clk); #1;
      if (stall) out_ready = 1'($urandom_range(0, 1));
    end
    if (hs != n_tiles * S) check("stream_timeout", 32'(hs), 32'(n_tiles * S));
    out_ready = 1'b1;
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 16; i++) begin
      first_acc[i] = -1; last_acc[i] = -1; last_hs[i] = -1; first_valid[i] = -1;
    end
    for (int i = 0; i < LANES; i++) in_data[i] = '0;

    #12 rst_n = 1'b1;
    @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst tile_last", 32'(tile_last), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    for (int i = 0; i < LANES; i++) check($sformatf("rst out_data%0d", i), 32'(out_data[i]), 32'd0);
    @(posedge clk); #1;

    // Single tile, forward and reversed skew, plus load-to-stream latency.
    fork
      load_tile(0);
      collect(0, 1, 1'b0);
    join
    check("latency tile0", 32'(first_valid[0]), 32'(last_acc[0] + 1));
    check("single bubbles", 32'(bubbles), 32'd0);
    check("single n_valid", 32'(n_valid), 32'(S));
    check("idle busy", 32'(busy), 32'd0);
    check("idle out_valid", 32'(out_valid), 32'd0);
    check("idle in_ready", 32'(in_ready), 32'd1);

    // Three back-to-back tiles: no bubbles, bank freed by tile 1 is refilled next cycle.
    fork
      begin
        load_tile(1);
        load_tile(2);
        load_tile(3);
      end
      collect(1, 3, 1'b0);
    join
    check("b2b bubbles", 32'(bubbles), 32'd0);
    check("b2b n_valid", 32'(n_valid), 32'(3 * S));
    check("bank reuse", 32'(first_acc[3]), 32'(last_hs[1] + 1));

    // Random downstream stalls: data must hold and match the no-stall sequence.
    fork
      begin
        load_tile(4);
        load_tile(5);
      end
      collect(4, 2, 1'b1);
    join
    check("stall idle busy", 32'(busy), 32'd0);

    // Flush at wavefront 3 of tile 6 with tile 7 half loaded; the flush-cycle beat is dropped.
    load_tile(6);
    drive_beat(7, 0, acc);
    drive_beat(7, 1, acc);
    @(posedge clk); #1;
    flush = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < LANES; i++) in_data[i] = 16'(7 * 256 + 16 * i + 2);
    @(negedge clk);
    check("preflush t3 lane0", 32'(out_data[0]), exp_val(6, 3, 0, 1'b0));
    check("preflush busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);
    check("flush busy", 32'(busy), 32'd0);
    fork
      load_tile(8);
      collect(8, 1, 1'b0);
    join
    check("post-flush latency", 32'(first_valid[8]), 32'(last_acc[8] + 1));

    // Asynchronous reset mid-stream.
    load_tile(9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("prereset out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async out_valid", 32'(out_valid), 32'd0);
    check("async in_ready", 32'(in_ready), 32'd1);
    check("async busy", 32'(busy), 32'd0);
    check("async rev busy", 32'(r_busy), 32'd0);
    check("async tile_last", 32'(tile_last), 32'd0);
    for (int i = 0; i < LANES; i++) check($sformatf("async out_data%0d", i), 32'(out_data[i]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    fork
      load_tile(10);
      collect(10, 1, 1'b0);
    join
    check("post-reset latency", 32'(first_valid[10]), 32'(last_acc[10] + 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
